// File: rtl/instr_encoder_if.sv
// Request/response bundle for the RV32I instruction encoder.
// The master issues encode requests and consumes the encoded word stream.
interface instr_encoder_if;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  fmt;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic        out_last;
    logic        out_err;

    modport master (
        output in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        input  in_ready, out_valid, out_instr, out_last, out_err
    );

    modport slave (
        input  in_valid, fmt, opcode, rd, rs1, rs2, funct3, funct7, imm, out_ready,
        output in_ready, out_valid, out_instr, out_last, out_err
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs register fields and an immediate into RV32I words; expands LI into LUI/ADDI.
// States: S_IDLE | accept requests, output register holds at most one word
//         S_LI_ADDI | LUI of an LI pair is presented, ADDI queued behind it
module instr_encoder (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_encoder_if.slave        bus
);

    localparam logic [2:0] FMT_R  = 3'd0;
    localparam logic [2:0] FMT_I  = 3'd1;
    localparam logic [2:0] FMT_S  = 3'd2;
    localparam logic [2:0] FMT_B  = 3'd3;
    localparam logic [2:0] FMT_U  = 3'd4;
    localparam logic [2:0] FMT_J  = 3'd5;
    localparam logic [2:0] FMT_LI = 3'd6;

    localparam logic [6:0]  OP_LUI = 7'b0110111;
    localparam logic [6:0]  OP_IMM = 7'b0010011;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef enum logic {
        S_IDLE,
        S_LI_ADDI
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic        r_out_valid;
    logic [31:0] r_out_instr;
    logic        r_out_last;
    logic        r_out_err;
    logic [4:0]  r_pend_rd;
    logic [11:0] r_pend_lo;

    logic        w_valid_nxt;
    logic [31:0] w_instr_nxt;
    logic        w_last_nxt;
    logic        w_err_nxt;
    logic        w_pend_ld;

    logic        w_in_ready;
    logic        w_accept;
    logic        w_out_hs;

    logic [11:0] w_lo;
    logic [19:0] w_hi;
    logic        w_fits12;
    logic        w_fits13;
    logic        w_fits21;

    logic [31:0] w_enc_word;
    logic        w_enc_err;
    logic        w_enc_pair;

    assign w_in_ready = (r_state == S_IDLE) && (!r_out_valid || bus.out_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_out_hs   = r_out_valid && bus.out_ready;

    // Adding 0x800 before taking the upper bits only carries into bit 12 when imm[11] is set.
    assign w_lo     = bus.imm[11:0];
    assign w_hi     = bus.imm[31:12] + {19'd0, bus.imm[11]};
    assign w_fits12 = (&bus.imm[31:11]) || !(|bus.imm[31:11]);
    assign w_fits13 = (&bus.imm[31:12]) || !(|bus.imm[31:12]);
    assign w_fits21 = (&bus.imm[31:20]) || !(|bus.imm[31:20]);

    always_comb begin
        w_enc_word = NOP;
        w_enc_err  = 1'b0;
        w_enc_pair = 1'b0;
        case (bus.fmt)
            FMT_R: begin
                w_enc_word = {bus.funct7, bus.rs2, bus.rs1, bus.funct3, bus.rd, bus.opcode};
            end
            FMT_I: begin
                w_enc_word = {bus.imm[11:0], bus.rs1, bus.funct3, bus.rd, bus.opcode};
                w_enc_err  = !w_fits12;
            end
            FMT_S: begin
                w_enc_word = {bus.imm[11:5], bus.rs2, bus.rs1, bus.funct3,
                              bus.imm[4:0], bus.opcode};
                w_enc_err  = !w_fits12;
            end
            FMT_B: begin
                w_enc_word = {bus.imm[12], bus.imm[10:5], bus.rs2, bus.rs1, bus.funct3,
                              bus.imm[4:1], bus.imm[11], bus.opcode};
                w_enc_err  = !w_fits13 || bus.imm[0];
            end
            FMT_U: begin
                w_enc_word = {bus.imm[31:12], bus.rd, bus.opcode};
                w_enc_err  = |bus.imm[11:0];
            end
            FMT_J: begin
                w_enc_word = {bus.imm[20], bus.imm[10:1], bus.imm[11], bus.imm[19:12],
                              bus.rd, bus.opcode};
                w_enc_err  = !w_fits21 || bus.imm[0];
            end
            FMT_LI: begin
                if (w_fits12) begin
                    w_enc_word = {w_lo, 5'd0, 3'b000, bus.rd, OP_IMM};
                end else if (w_lo == 12'd0) begin
                    w_enc_word = {w_hi, bus.rd, OP_LUI};
                end else begin
                    w_enc_word = {w_hi, bus.rd, OP_LUI};
                    w_enc_pair = 1'b1;
                end
            end
            default: begin
                w_enc_word = NOP;
                w_enc_err  = 1'b1;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_valid_nxt = r_out_valid;
        w_instr_nxt = r_out_instr;
        w_last_nxt  = r_out_last;
        w_err_nxt   = r_out_err;
        w_pend_ld   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_valid_nxt = 1'b1;
                    w_instr_nxt = w_enc_word;
                    w_last_nxt  = !w_enc_pair;
                    w_err_nxt   = w_enc_err;
                    if (w_enc_pair) begin
                        w_pend_ld   = 1'b1;
                        w_state_nxt = S_LI_ADDI;
                    end
                end else if (w_out_hs) begin
                    w_valid_nxt = 1'b0;
                end
            end
            S_LI_ADDI: begin
                if (w_out_hs) begin
                    w_valid_nxt = 1'b1;
                    w_instr_nxt = {r_pend_lo, r_pend_rd, 3'b000, r_pend_rd, OP_IMM};
                    w_last_nxt  = 1'b1;
                    w_err_nxt   = 1'b0;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_instr <= 32'd0;
            r_out_last  <= 1'b0;
            r_out_err   <= 1'b0;
            r_pend_rd   <= 5'd0;
            r_pend_lo   <= 12'd0;
        end else begin
            r_out_valid <= w_valid_nxt;
            r_out_instr <= w_instr_nxt;
            r_out_last  <= w_last_nxt;
            r_out_err   <= w_err_nxt;
            if (w_pend_ld) begin
                r_pend_rd <= bus.rd;
                r_pend_lo <= w_lo;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_instr = r_out_instr;
    assign bus.out_last  = r_out_last;
    assign bus.out_err   = r_out_err;

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized bench for instr_encoder: expected word stream comes from an arithmetic
// reference model queued per accepted request and compared every cycle.
module tb_instr_encoder;

    typedef struct packed {
        logic [31:0] w;
        logic        last;
        logic        err;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    exp_t q[$];

    instr_encoder_if bus ();

    instr_encoder dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference encoder: range rules as signed intervals, LI split by arithmetic.
    function automatic int model(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                                 input logic [4:0] rs1, input logic [4:0] rs2,
                                 input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] imm, output exp_t e0, output exp_t e1);
        longint s;
        logic [31:0] hi_full;
        logic [31:0] lo;
        s  = longint'($signed(imm));
        e1 = '0;
        e0.last = 1'b1;
        e0.err  = 1'b0;
        case (f)
            3'd0: e0.w = {f7, rs2, rs1, f3, rd, op};
            3'd1: begin
                e0.w = {imm[11:0], rs1, f3, rd, op};
                e0.err = (s < -2048) || (s > 2047);
            end
            3'd2: begin
                e0.w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
                e0.err = (s < -2048) || (s > 2047);
            end
            3'd3: begin
                e0.w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
                e0.err = (s < -4096) || (s > 4095) || (s % 2 != 0);
            end
            3'd4: begin
                e0.w = {imm[31:12], rd, op};
                e0.err = (imm % 4096) != 0;
            end
            3'd5: begin
                e0.w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
                e0.err = (s < -1048576) || (s > 1048575) || (s % 2 != 0);
            end
            3'd6: begin
                lo      = imm % 4096;
                hi_full = (imm + 32'h800) / 4096;
                if (s >= -2048 && s <= 2047) begin
                    e0.w = (lo << 20) | (32'(rd) << 7) | 32'h13;
                end else if (lo == 0) begin
                    e0.w = (hi_full << 12) | (32'(rd) << 7) | 32'h37;
                end else begin
                    e0.w    = (hi_full << 12) | (32'(rd) << 7) | 32'h37;
                    e0.last = 1'b0;
                    e1.w    = (lo << 20) | (32'(rd) << 15) | (32'(rd) << 7) | 32'h13;
                    e1.last = 1'b1;
                    e1.err  = 1'b0;
                    return 2;
                end
            end
            default: begin
                e0.w   = 32'h13;
                e0.err = 1'b1;
            end
        endcase
        return 1;
    endfunction

    // Compare process: checks handshake signals and the presented word every cycle.
    always @(negedge clk) begin
        exp_t e0, e1;
        int   n;
        logic exp_rdy;
        if (!rst_n) begin
            q.delete();
        end else begin
            exp_rdy = (q.size() <= 1) && (q.size() == 0 || bus.out_ready);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
            if (bus.out_valid && q.size() > 0) begin
                check("out_instr", bus.out_instr, q[0].w);
                check("out_last", 32'(bus.out_last), 32'(q[0].last));
                check("out_err", 32'(bus.out_err), 32'(q[0].err));
            end
            if (q.size() > 0 && bus.out_ready) void'(q.pop_front());
            if (bus.in_valid && bus.in_ready) begin
                n = model(bus.fmt, bus.opcode, bus.rd, bus.rs1, bus.rs2, bus.funct3,
                          bus.funct7, bus.imm, e0, e1);
                q.push_back(e0);
                if (n == 2) q.push_back(e1);
            end
        end
    end

    // Called aligned to posedge+2; returns aligned to posedge+2 just after the accept edge.
    task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
        int n;
        n = 0;
        bus.fmt = f; bus.opcode = op; bus.rd = rd; bus.rs1 = rs1; bus.rs2 = rs2;
        bus.funct3 = f3; bus.funct7 = f7; bus.imm = imm;
        bus.in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.in_ready) break;
            n++;
            if (n > 200) begin
                n_checks++;
                $display("FAIL send_timeout: in_ready stuck low, got 0 expected 1");
                break;
            end
        end
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        bus.imm = $urandom;
        bus.rd  = 5'($urandom);
    endtask

    task automatic align();
        @(posedge clk);
        #2;
    endtask

    function automatic logic [31:0] rand_imm();
        logic [31:0] v;
        logic [31:0] edges [8];
        edges = '{32'h7FF, 32'h800, 32'hFFFFF800, 32'hFFFFF7FF,
                  32'hFFF, 32'h1000, 32'hFFFFF000, 32'h000FFFFE};
        v = $urandom;
        case ($urandom_range(0, 4))
            0: return v;
            1: return 32'($signed(12'(v)));
            2: return 32'($signed(v[12:0])) & 32'hFFFF_FFFE;
            3: return v & 32'hFFFF_F000;
            default: return edges[$urandom_range(0, 7)];
        endcase
    endfunction

    initial begin
        exp_t e0, e1;
        int   n;
        bit   done;
        n_checks = 0;
        n_pass   = 0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        bus.fmt = '0; bus.opcode = '0; bus.rd = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.funct3 = '0; bus.funct7 = '0; bus.imm = '0;
        #3;
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_instr", bus.out_instr, 32'd0);
        check("rst_out_last", 32'(bus.out_last), 32'd0);
        check("rst_out_err", 32'(bus.out_err), 32'd0);

        n = model(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC, e0, e1);
        check("pin_b", e0.w, 32'hFE208EE3);
        check("pin_b_err", 32'(e0.err), 32'd0);
        n = model(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800, e0, e1);
        check("pin_j", e0.w, 32'h001000EF);
        n = model(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h801, e0, e1);
        check("pin_j_err", 32'(e0.err), 32'd1);
        n = model(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, e0, e1);
        check("pin_i_pos", {e0.w[31:1], e0.err}, {32'h80000092 >> 1, 1'b1});
        n = model(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, e0, e1);
        check("pin_i_neg", {e0.w[31:1], e0.err}, {32'h80000092 >> 1, 1'b0});
        n = model(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, e0, e1);
        check("pin_li_n", 32'(n), 32'd2);
        check("pin_li_lui", e0.w, 32'h123462B7);
        check("pin_li_addi", e1.w, 32'hFFF28293);
        n = model(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800, e0, e1);
        check("pin_li_short_addi", e0.w, 32'h80000293);
        n = model(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000, e0, e1);
        check("pin_li_short_lui", e0.w, 32'h000102B7);

        align();
        rst_n = 1'b1;
        align();

        send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFFFFFC);
        @(negedge clk);
        check("dut_b", bus.out_instr, 32'hFE208EE3);
        check("dut_b_last", 32'(bus.out_last), 32'd1);
        align();
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h800);
        send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h801);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        send(3'd7, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'h0);
        send(3'd0, 7'h33, 5'd3, 5'd4, 5'd5, 3'd1, 7'h20, 32'hDEADBEEF);
        align();

        bus.out_ready = 1'b0;
        send(3'd6, 7'h7F, 5'd5, 5'd9, 5'd9, 3'd7, 7'h7F, 32'h12345FFF);
        repeat (3) @(negedge clk);
        check("hold_lui", bus.out_instr, 32'h123462B7);
        check("hold_lui_last", 32'(bus.out_last), 32'd0);
        align();
        bus.out_ready = 1'b1;
        align();
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("hold_addi", bus.out_instr, 32'hFFF28293);
        check("hold_addi_last", 32'(bus.out_last), 32'd1);
        align();
        bus.out_ready = 1'b1;
        align();
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00010000);
        align();

        bus.out_ready = 1'b0;
        send(3'd6, 7'd0, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF);
        align();
        rst_n = 1'b0;
        #1;
        check("midpair_rst_valid", 32'(bus.out_valid), 32'd0);
        check("midpair_rst_instr", bus.out_instr, 32'd0);
        check("midpair_rst_last", 32'(bus.out_last), 32'd0);
        check("midpair_rst_err", 32'(bus.out_err), 32'd0);
        check("midpair_rst_ready", 32'(bus.in_ready), 32'd1);
        align();
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFF800);
        @(negedge clk);
        check("post_rst_word", bus.out_instr, 32'h80000093);
        align();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 500; i++) begin
                    send(3'($urandom_range(0, 7)), 7'($urandom), 5'($urandom), 5'($urandom),
                         5'($urandom), 3'($urandom), 7'($urandom), rand_imm());
                    if ($urandom_range(0, 3) == 0) align();
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    align();
                    if (!done) bus.out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        bus.out_ready = 1'b1;
        for (int i = 0; i < 50 && q.size() > 0; i++) @(negedge clk);
        align();
        check("drain_empty", 32'(q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
